// File: rtl/board_ram_write_arbiter.sv
// board_ram_write_arbiter: owns the write port of the board RAM and shares it between
// two requesters and a built-in clear sequence, with optional vertical-blank gating.
// Ports:
//   i_clk, i_rst        clock / async active-high reset
//   i_vblank            vertical-blank window (write gate when BLANK_GATE=1)
//   i_req0/1            level write requests, held until the matching ack
//   i_addr0/1, i_data0/1 request address/data, stable while requested
//   o_ack0/1            1-cycle pulse when a port's write is issued
//   i_clr_req           start a clear of the whole RAM (taken when idle and gated)
//   i_clr_data          fill value captured at clear start
//   o_clr_busy          clear in progress
//   o_clr_done          1-cycle pulse with the last clear write
//   o_ram_wrclk         RAM write clock (= i_clk)
//   o_ram_wraddr/data   registered write address/data, held between writes
//   o_ram_wren          registered write enable
module board_ram_write_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int BLANK_GATE = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vblank,
    input  logic              i_req0,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [DATA_W-1:0] i_data0,
    output logic              o_ack0,
    input  logic              i_req1,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_data1,
    output logic              o_ack1,
    input  logic              i_clr_req,
    input  logic [DATA_W-1:0] i_clr_data,
    output logic              o_clr_busy,
    output logic              o_clr_done,
    output logic              o_ram_wrclk,
    output logic [ADDR_W-1:0] o_ram_wraddr,
    output logic [DATA_W-1:0] o_ram_data,
    output logic              o_ram_wren
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [ADDR_W-1:0] LAST = '1;
    state_t            r_state, w_state;
    logic              r_last, w_last;
    logic [ADDR_W-1:0] r_cnt, w_cnt, w_addr;
    logic [DATA_W-1:0] r_fill, w_fill, w_data;
    logic              w_gate, w_pick1, w_wren, w_ack0, w_ack1, w_busy, w_done;
    assign o_ram_wrclk = i_clk;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state;
    always_comb begin
        w_state = r_state;
        w_last  = r_last;
        w_cnt   = r_cnt;
        w_fill  = r_fill;
        w_addr  = o_ram_wraddr;
        w_data  = o_ram_data;
        w_wren  = 1'b0;
        w_ack0  = 1'b0;
        w_ack1  = 1'b0;
        w_busy  = o_clr_busy;
        w_done  = 1'b0;
        w_gate  = (BLANK_GATE == 0) || i_vblank;
        // r_last is the port granted most recently; on a tie the other port wins
        w_pick1 = i_req1 && (!i_req0 || !r_last);
        if (w_gate && r_state == IDLE) begin
            if (i_clr_req) begin
                w_state = CLEAR;
                w_busy  = 1'b1;
                w_cnt   = '0;
                w_fill  = i_clr_data;
            end else if (i_req0 || i_req1) begin
                w_wren = 1'b1;
                w_ack0 = !w_pick1;
                w_ack1 = w_pick1;
                w_addr = w_pick1 ? i_addr1 : i_addr0;
                w_data = w_pick1 ? i_data1 : i_data0;
                w_last = w_pick1;
            end
        end else if (w_gate && r_state == CLEAR) begin
            w_wren  = 1'b1;
            w_addr  = r_cnt;
            w_data  = r_fill;
            w_cnt   = (r_cnt == LAST) ? r_cnt : r_cnt + 1'b1;
            w_done  = (r_cnt == LAST);
            w_busy  = (r_cnt != LAST);
            w_state = (r_cnt == LAST) ? IDLE : CLEAR;
        end
    end
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_last       <= 1'b1;
            r_cnt        <= '0;
            r_fill       <= '0;
            o_ram_wraddr <= '0;
            o_ram_data   <= '0;
            o_ram_wren   <= 1'b0;
            o_ack0       <= 1'b0;
            o_ack1       <= 1'b0;
            o_clr_busy   <= 1'b0;
            o_clr_done   <= 1'b0;
        end else begin
            r_last       <= w_last;
            r_cnt        <= w_cnt;
            r_fill       <= w_fill;
            o_ram_wraddr <= w_addr;
            o_ram_data   <= w_data;
            o_ram_wren   <= w_wren;
            o_ack0       <= w_ack0;
            o_ack1       <= w_ack1;
            o_clr_busy   <= w_busy;
            o_clr_done   <= w_done;
        end
endmodule

// File: tb/tb_board_ram_write_arbiter.sv
// tb_board_ram_write_arbiter: randomized and directed bench for two arbiter instances
// (blank-gated and ungated) sharing one stimulus, checked against a behavioural model.
module tb_board_ram_write_arbiter;
    logic       clk = 1'b0, rst = 1'b1, vblank = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, clr_req = 1'b0;
    logic [3:0] addr0 = '0, addr1 = '0;
    logic [7:0] data0 = '0, data1 = '0, clr_data = '0;
    logic       ack0 [2], ack1 [2], busy [2], done [2], wren [2], wrclk [2];
    logic [3:0] waddr [2];
    logic [7:0] wdata [2];
    logic       e_wren [2], e_ack0 [2], e_ack1 [2], e_busy [2], e_done [2];
    logic [3:0] e_addr [2];
    logic [7:0] e_data [2];
    int         rem [2];
    logic [7:0] fill [2];
    logic       last1 [2];
    int         n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    board_ram_write_arbiter #(.ADDR_W(4), .DATA_W(8), .BLANK_GATE(1)) dut_g (
        .i_clk(clk), .i_rst(rst), .i_vblank(vblank),
        .i_req0(req0), .i_addr0(addr0), .i_data0(data0), .o_ack0(ack0[0]),
        .i_req1(req1), .i_addr1(addr1), .i_data1(data1), .o_ack1(ack1[0]),
        .i_clr_req(clr_req), .i_clr_data(clr_data), .o_clr_busy(busy[0]), .o_clr_done(done[0]),
        .o_ram_wrclk(wrclk[0]), .o_ram_wraddr(waddr[0]), .o_ram_data(wdata[0]), .o_ram_wren(wren[0]));
    board_ram_write_arbiter #(.ADDR_W(4), .DATA_W(8), .BLANK_GATE(0)) dut_u (
        .i_clk(clk), .i_rst(rst), .i_vblank(vblank),
        .i_req0(req0), .i_addr0(addr0), .i_data0(data0), .o_ack0(ack0[1]),
        .i_req1(req1), .i_addr1(addr1), .i_data1(data1), .o_ack1(ack1[1]),
        .i_clr_req(clr_req), .i_clr_data(clr_data), .o_clr_busy(busy[1]), .o_clr_done(done[1]),
        .o_ram_wrclk(wrclk[1]), .o_ram_wraddr(waddr[1]), .o_ram_data(wdata[1]), .o_ram_wren(wren[1]));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask
    function automatic logic pick1(input logic r0, input logic r1, input logic l1);
        return (r0 && r1) ? !l1 : r1;
    endfunction
    // Model: a clear is a count of remaining writes; write address = DEPTH - remaining.
    always @(posedge clk or posedge rst)
        for (int k = 0; k < 2; k++)
            if (rst) begin
                rem[k] <= 0; fill[k] <= '0; last1[k] <= 1'b1;
                e_wren[k] <= 0; e_ack0[k] <= 0; e_ack1[k] <= 0; e_busy[k] <= 0; e_done[k] <= 0;
                e_addr[k] <= '0; e_data[k] <= '0;
            end else begin
                e_wren[k] <= 0; e_ack0[k] <= 0; e_ack1[k] <= 0; e_done[k] <= 0;
                if (k == 1 || vblank) begin
                    if (rem[k] > 0) begin
                        e_wren[k] <= 1;
                        e_addr[k] <= 4'(16 - rem[k]);
                        e_data[k] <= fill[k];
                        rem[k]    <= rem[k] - 1;
                        e_done[k] <= (rem[k] == 1);
                        e_busy[k] <= (rem[k] != 1);
                    end else if (clr_req) begin
                        rem[k] <= 16; fill[k] <= clr_data; e_busy[k] <= 1;
                    end else if (req0 || req1) begin
                        e_wren[k]  <= 1;
                        e_ack1[k]  <= pick1(req0, req1, last1[k]);
                        e_ack0[k]  <= !pick1(req0, req1, last1[k]);
                        e_addr[k]  <= pick1(req0, req1, last1[k]) ? addr1 : addr0;
                        e_data[k]  <= pick1(req0, req1, last1[k]) ? data1 : data0;
                        last1[k]   <= pick1(req0, req1, last1[k]);
                    end
                end
            end
    always @(negedge clk)
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wren%0d", k), 32'(wren[k]), 32'(e_wren[k]));
            chk($sformatf("ack0_%0d", k), 32'(ack0[k]), 32'(e_ack0[k]));
            chk($sformatf("ack1_%0d", k), 32'(ack1[k]), 32'(e_ack1[k]));
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(e_busy[k]));
            chk($sformatf("done%0d", k), 32'(done[k]), 32'(e_done[k]));
            chk($sformatf("addr%0d", k), 32'(waddr[k]), 32'(e_addr[k]));
            chk($sformatf("data%0d", k), 32'(wdata[k]), 32'(e_data[k]));
        end
    task automatic step(input int n);
        repeat (n) @(posedge clk) #1;
    endtask
    task automatic wait_ack(input string tag, input bit port1);
        int t = 0;
        while (!(port1 ? e_ack1[0] : e_ack0[0]) && t < 60) begin step(1); t++; end
        if (t >= 60) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask
    task automatic wait_wr(input string tag, input logic [3:0] a);
        int t = 0;
        while (!(e_wren[0] && e_busy[0] && e_addr[0] == a) && t < 60) begin step(1); t++; end
        if (t >= 60) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask
    initial begin
        step(3);
        rst = 0;
        vblank = 0; req0 = 1; addr0 = 4'd3; data0 = 8'h2A;
        step(4);
        vblank = 1;
        wait_ack("t1", 0);
        req0 = 0;
        step(2);
        req0 = 1; addr0 = 4'd1; data0 = 8'h11; req1 = 1; addr1 = 4'd2; data1 = 8'h22;
        step(8);
        req0 = 0; req1 = 0;
        step(2);
        clr_data = 8'h00; clr_req = 1;
        step(1);
        clr_req = 0;
        step(20);
        clr_data = 8'h55; clr_req = 1;
        step(1);
        clr_req = 0;
        wait_wr("t4", 4'd5);
        vblank = 0;
        step(10);
        vblank = 1;
        step(20);
        clr_data = 8'h3C; clr_req = 1; req1 = 1; addr1 = 4'd9; data1 = 8'h99;
        step(1);
        clr_req = 0;
        wait_wr("t5", 4'd8);
        rst = 1;
        step(2);
        rst = 0;
        wait_ack("t5b", 1);
        req1 = 0;
        step(2);
        vblank = 0; req1 = 1; addr1 = 4'd15; data1 = 8'hFF;
        step(1);
        req1 = 0;
        step(3);
        for (int i = 0; i < 3000; i++) begin
            vblank = ($urandom_range(9) < 7);
            if (e_busy[0]) clr_req = 0;
            else if ($urandom_range(39) == 0) begin clr_req = 1; clr_data = 8'($urandom); end
            if (e_ack0[0] || (!req0 && $urandom_range(2) == 0)) begin
                req0 = e_ack0[0] ? 1'($urandom) : 1'b1;
                addr0 = 4'($urandom); data0 = 8'($urandom);
            end
            if (e_ack1[0] || (!req1 && $urandom_range(2) == 0)) begin
                req1 = e_ack1[0] ? 1'($urandom) : 1'b1;
                addr1 = 4'($urandom); data1 = 8'($urandom);
            end
            rst = ($urandom_range(499) == 0);
            step(1);
        end
        rst = 0;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
